tdm_demux4_seq: RTL and testbench

//  Receive end of the team's 4:1 select-multiplexed serial link. The transmit side places channel
//  i[s] on one wire per slot, with s stepping 0..3. This block recovers the 4 channels.

---
 rtl/tdm_demux4_seq_pkg.sv | 13 +
 rtl/tdm_demux4_seq_dec.sv | 29 ++
 rtl/tdm_demux4_seq.sv | 100 ++++++++++
 tb/tb_tdm_demux4_seq.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/tdm_demux4_seq_pkg.sv
// Shared definitions for the 4-slot TDM receive demultiplexer.
// Frame geometry defaults and FSM state encoding.
package tdm_demux4_seq_pkg;

  localparam int NCH_DEF = 4;
  localparam int SW_DEF  = 2;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } state_e;

endpackage

// File: rtl/tdm_demux4_seq_dec.sv
// Gated slot decoder: one-hot load enables from the slot index,
// built as a binary tree of 1-to-2 splits, MSB of sel first.
module demux1to4_dec
  import tdm_demux4_seq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW  = SW_DEF
) (
  input  logic          we,
  input  logic [SW-1:0] sel,
  output logic [NCH-1:0] ld
);

  // Heap-ordered tree: node p splits into 2p+1 and 2p+2.
  logic [2*NCH-2:0] node;

  assign node[0] = we;

  for (genvar l = 0; l < SW; l++) begin : g_lvl
    for (genvar n = 0; n < (1 << l); n++) begin : g_node
      localparam int P = (1 << l) - 1 + n;
      assign node[2*P+1] = node[P] & ~sel[SW-1-l];
      assign node[2*P+2] = node[P] &  sel[SW-1-l];
    end
  end

  assign ld = node[2*NCH-2:NCH-1];

endmodule

// File: rtl/tdm_demux4_seq.sv
// TDM link receiver: locks a slot counter to frame sync and
// assembles each frame into a registered parallel word.
module tdm_demux4_seq
  import tdm_demux4_seq_pkg::*;
#(
  parameter int NCH = NCH_DEF,
  parameter int SW  = SW_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           en,
  input  logic           din,
  input  logic           sync,
  output logic [NCH-1:0] y,
  output logic [SW-1:0]  sel,
  output logic           frame_valid,
  output logic           sync_err,
  output logic           locked
);

  state_e         state_q, state_d;
  logic [SW-1:0]  sel_q, sel_d;
  logic [NCH-2:0] shadow_q, shadow_d;
  logic [NCH-1:0] y_q, y_d;
  logic           fv_q, fv_d;
  logic           err_q, err_d;

  logic           misplaced;
  logic           lock_wr;
  logic           restart;
  logic [NCH-1:0] ld;

  assign misplaced = en & sync & (sel_q != '0);
  assign lock_wr   = en & (state_q == ST_LOCK) & ~misplaced;
  assign restart   = en & sync &
                     ((state_q == ST_HUNT) | misplaced);

  demux1to4_dec #(
    .NCH (NCH),
    .SW  (SW)
  ) u_dec (
    .we  (lock_wr),
    .sel (sel_q),
    .ld  (ld)
  );

  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    shadow_d = shadow_q;
    y_d      = y_q;
    fv_d     = 1'b0;
    err_d    = 1'b0;
    unique case (1'b1)
      restart: begin
        shadow_d[0] = din;
        sel_d       = SW'(1);
        state_d     = ST_LOCK;
        err_d       = (state_q == ST_LOCK);
      end
      lock_wr: begin
        for (int k = 0; k < NCH - 1; k++) begin
          if (ld[k]) shadow_d[k] = din;
        end
        sel_d = sel_q + 1'b1;
        // Last slot bypasses the shadow straight into y.
        if (ld[NCH-1]) begin
          y_d  = {din, shadow_q};
          fv_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_HUNT;
      sel_q    <= '0;
      shadow_q <= '0;
      y_q      <= '0;
      fv_q     <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      shadow_q <= shadow_d;
      y_q      <= y_d;
      fv_q     <= fv_d;
      err_q    <= err_d;
    end
  end

  assign y           = y_q;
  assign sel         = sel_q;
  assign frame_valid = fv_q;
  assign sync_err    = err_q;
  assign locked      = (state_q == ST_LOCK);

endmodule

// File: tb/tb_tdm_demux4_seq.sv
// Directed bench for tdm_demux4_seq: vector table plus
// hand-written gap, reset and back-to-back sequences.
module tb_tdm_demux4_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       din = 1'b0;
  logic       sync = 1'b0;
  logic [3:0] y;
  logic [1:0] sel;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       din;
    logic       sync;
    logic [3:0] y;
    logic [1:0] sel;
    logic       fv;
    logic       err;
    logic       lock;
  } vec_t;

  vec_t tbl[$];

  tdm_demux4_seq dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .din         (din),
    .sync        (sync),
    .y           (y),
    .sel         (sel),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic e,
                      input logic d, input logic s);
    rst  = r;
    en   = e;
    din  = d;
    sync = s;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic e,
                     input logic d, input logic s,
                     input logic [3:0] ey,
                     input logic [1:0] es,
                     input logic ef, input logic ee,
                     input logic el);
    vec_t v;
    v.rst = r; v.en = e; v.din = d; v.sync = s;
    v.y = ey; v.sel = es; v.fv = ef; v.err = ee;
    v.lock = el;
    tbl.push_back(v);
  endtask

  task automatic chk_all(input string tag,
                         input logic [3:0] ey,
                         input logic [1:0] es,
                         input logic ef, input logic ee,
                         input logic el);
    chk({tag, ".y"}, 32'(y), 32'(ey));
    chk({tag, ".sel"}, 32'(sel), 32'(es));
    chk({tag, ".fv"}, 32'(frame_valid), 32'(ef));
    chk({tag, ".err"}, 32'(sync_err), 32'(ee));
    chk({tag, ".lock"}, 32'(locked), 32'(el));
  endtask

  initial begin
    // test 1: reset, then unsynced samples ignored
    add(1,0,0,0, 4'b0000,0,0,0,0);
    add(1,0,0,0, 4'b0000,0,0,0,0);
    add(0,1,1,0, 4'b0000,0,0,0,0);
    add(0,1,0,0, 4'b0000,0,0,0,0);
    add(0,1,1,0, 4'b0000,0,0,0,0);
    add(0,1,0,0, 4'b0000,0,0,0,0);
    // test 2: frame 1101
    add(0,1,1,1, 4'b0000,1,0,0,1);
    add(0,1,0,0, 4'b0000,2,0,0,1);
    add(0,1,1,0, 4'b0000,3,0,0,1);
    add(0,1,1,0, 4'b1101,0,1,0,1);
    add(0,0,0,0, 4'b1101,0,0,0,1);
    // test 4: sync at slot 0 allowed, then misplaced
    add(0,1,0,1, 4'b1101,1,0,0,1);
    add(0,1,1,0, 4'b1101,2,0,0,1);
    add(0,1,1,1, 4'b1101,1,0,1,1);
    add(0,1,0,0, 4'b1101,2,0,0,1);
    add(0,1,0,0, 4'b1101,3,0,0,1);
    add(0,1,1,0, 4'b1001,0,1,0,1);
    add(0,0,1,1, 4'b1001,0,0,0,1);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].en,
           tbl[i].din, tbl[i].sync);
      chk_all($sformatf("vec%0d", i), tbl[i].y,
              tbl[i].sel, tbl[i].fv, tbl[i].err,
              tbl[i].lock);
    end

    // test 3: en gap of 3 clocks between slots 1 and 2
    step(1,0,0,0);
    chk_all("t3.rst", 4'b0000, 0, 0, 0, 0);
    step(0,1,1,1);
    step(0,1,0,0);
    for (int i = 0; i < 3; i++) begin
      step(0,0,1,1);
      chk_all($sformatf("t3.gap%0d", i),
              4'b0000, 2, 0, 0, 1);
    end
    step(0,1,1,0);
    chk_all("t3.s2", 4'b0000, 3, 0, 0, 1);
    step(0,1,1,0);
    chk_all("t3.done", 4'b1101, 0, 1, 0, 1);
    step(0,0,0,0);
    chk_all("t3.after", 4'b1101, 0, 0, 0, 1);

    // test 5: reset mid-frame at sel=2
    step(0,1,0,1);
    step(0,1,1,0);
    chk_all("t5.mid", 4'b1101, 2, 0, 0, 1);
    step(1,1,1,0);
    chk_all("t5.rst", 4'b0000, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0,1,1,0);
      chk_all($sformatf("t5.hunt%0d", i),
              4'b0000, 0, 0, 0, 0);
    end

    // test 6: one sync, three back-to-back frames
    begin
      logic [3:0] pat [3];
      logic [3:0] cur;
      logic [3:0] ylast;
      pat[0] = 4'b0001;
      pat[1] = 4'b1000;
      pat[2] = 4'b1111;
      ylast = 4'b0000;
      for (int f = 0; f < 3; f++) begin
        cur = pat[f];
        for (int s = 0; s < 4; s++) begin
          step(0, 1, cur[s], (f == 0 && s == 0));
          if (s == 3) ylast = cur;
          chk_all($sformatf("t6.f%0d.s%0d", f, s),
                  ylast, 2'((s + 1) % 4),
                  (s == 3), 0, 1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: sim time exceeded");
    $fatal(1, "timeout");
  end

endmodule
